serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add a, b, cin; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 cin  input  1  carry-in, captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse: sum/cout hold a new result.
REQ-010 sum  output  WIDTH  registered result, a + b + cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the result.

Function
REQ-012 Bit-serial: exactly one full-adder evaluation per clock, LSB first, carry held in a flop between bits.
REQ-013 States IDLE, RUN, DONE; transitions: IDLE -start-> RUN; RUN -(bit WIDTH-1 processed)-> DONE; DONE -start-> RUN; DONE -!start-> IDLE.
REQ-014 Start accepted only in IDLE or DONE; acceptance loads a, b into shift registers, cin into the carry flop, bit counter to 0.
REQ-015 start while in RUN is ignored; operands, counter and state are unaffected.
REQ-016 Each RUN edge: shift fa sum into result shift register from MSB side, shift a/b right by one, carry <= fa carry, counter +1.
REQ-017 On the edge processing bit WIDTH-1: sum <= full result, cout <= final carry, state <= DONE.
REQ-018 Latency: start accepted at edge E0 -> done high in the cycle following edge E(WIDTH); i.e. done is asserted WIDTH cycles after acceptance.
REQ-019 done = (state == DONE); busy = (state == RUN); never both high.
REQ-020 sum/cout change only on the REQ-017 edge; they hold the last result through IDLE and during a following RUN.
REQ-021 Back-to-back: start high during DONE begins the next addition with no idle cycle; throughput one result per WIDTH+1 cycles max.
REQ-022 Counter is ceil(log2(WIDTH)) bits wide; it shall not wrap within one operation.

Reset
REQ-023 rst_n low immediately forces state IDLE, busy 0, done 0, sum 0, cout 0, carry flop 0, counter 0, shift registers 0, regardless of clk.
REQ-024 Reset mid-operation abandons the addition; no done pulse follows; first start after rst_n rises behaves as from power-up.
REQ-025 Release of rst_n is synchronous to clk at the system level; no start shall be issued in the same cycle as release.

Structure
REQ-026 Shared package serial_adder_pkg holds the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and DEFAULT_WIDTH=8.
REQ-027 One sub-module instance: the team's existing fulladder (ports a, b, c, sum, carry), driven from shift-register LSBs and the carry flop.
REQ-028 All state and datapath in one always block on posedge clk / negedge rst_n; no latches, no combinational loops.

Verification (WIDTH=8)
REQ-029 a=0x00, b=0x00, cin=0, start 1 cycle -> done after 8 cycles, sum=0x00, cout=0; busy high exactly 8 cycles.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0.
REQ-031 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then start held high in DONE with a=0x12, b=0x34, cin=0 -> next done 9 cycles after first done, sum=0x46, cout=0.
REQ-032 Start 0x0F+0x01 then pulse start with a=0xFF, b=0xFF at RUN cycle 3 -> ignored; result sum=0x10, cout=0; single done pulse.
REQ-033 Start 0xFF+0xFF, assert rst_n low at RUN cycle 4 (asynchronously, mid-cycle) -> all outputs 0 immediately, no done; after release, 0x03+0x04 -> sum=0x07, cout=0.
REQ-034 Random: 1000 operand/cin triples with random start gaps, compared against a+b+cin reference; zero mismatches, every done exactly 8 cycles after acceptance.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder.
// Purely combinational; one evaluation per serial step.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Result and carry-out are registered and held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last;
  logic             go;

  fulladder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .c    (carry),
    .sum  (fa_s),
    .carry(fa_c)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign go   = start && (state != RUN);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter holds at WIDTH-1 on the final step so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go) begin
        sa    <= a;
        sb    <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        res   <= {fa_s, res[WIDTH-1:1]};
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        carry <= fa_c;
        if (last) begin
          sum  <= {fa_s, res[WIDTH-1:1]};
          cout <= fa_c;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8).
// Stimulus predicts acceptance and results; a monitor checks each done.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ready_at = 0;
  int   accepted = 0;
  int   busy_cnt = 0;
  int   done_cycs[$];
  exp_t q[$];
  logic [7:0] last_sum = '0;
  logic       last_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (busy && done) check("busy_and_done", 1, 0);
      if (done) begin
        done_cycs.push_back(cyc);
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", {24'd0, sum}, {24'd0, e.s});
          check("cout", {31'd0, cout}, {31'd0, e.c});
          check("latency", cyc - e.acc, W);
          last_sum  = e.s;
          last_cout = e.c;
        end
      end else begin
        check("sum_hold", {23'd0, cout, sum}, {23'd0, last_cout, last_sum});
      end
    end
  end

  // Drive one cycle; predict whether the next edge accepts the start.
  task automatic step(input bit s, input logic [7:0] av,
                      input logic [7:0] bv, input bit c);
    @(negedge clk);
    start = s;
    a = av;
    b = bv;
    cin = c;
    if (s && (cyc + 1 >= ready_at)) begin
      exp_t e;
      logic [8:0] full;
      full = {1'b0, av} + {1'b0, bv} + {8'd0, c};
      e.s = full[7:0];
      e.c = full[8];
      e.acc = cyc + 1;
      q.push_back(e);
      ready_at = cyc + 2 + W;
      accepted++;
    end
  endtask

  task automatic drain();
    step(0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    last_sum = '0;
    last_cout = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_at = cyc + 2;
    @(negedge clk);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int d0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    rst_n = 1'b1;
    ready_at = cyc + 2;
    @(negedge clk);

    busy_cnt = 0;
    d0 = done_cycs.size();
    step(1, 8'h00, 8'h00, 0);
    drain();
    check("zero_busy_cycles", busy_cnt, W);
    check("zero_done_count", done_cycs.size() - d0, 1);

    step(1, 8'hFF, 8'h01, 0);
    drain();
    step(1, 8'h7F, 8'h01, 0);
    drain();

    step(1, 8'hA5, 8'h5A, 1);
    repeat (9) step(1, 8'h12, 8'h34, 0);
    drain();
    n0 = done_cycs.size();
    if (n0 >= 2) check("b2b_spacing", done_cycs[n0-1] - done_cycs[n0-2], W + 1);
    else check("b2b_done_count", n0, 2);

    d0 = done_cycs.size();
    step(1, 8'h0F, 8'h01, 0);
    step(0, 8'h00, 8'h00, 0);
    step(0, 8'h00, 8'h00, 0);
    step(1, 8'hFF, 8'hFF, 0);
    drain();
    check("ignored_done_count", done_cycs.size() - d0, 1);

    step(1, 8'hFF, 8'hFF, 0);
    repeat (4) step(0, 8'h00, 8'h00, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_sum", {24'd0, sum}, 0);
    check("arst_cout", {31'd0, cout}, 0);
    d0 = done_cycs.size();
    do_reset();
    repeat (12) @(negedge clk);
    check("arst_no_done", done_cycs.size() - d0, 0);
    step(1, 8'h03, 8'h04, 0);
    drain();

    n0 = accepted;
    while (accepted < n0 + 1000)
      step($urandom_range(0, 9) < 4, 8'($urandom), 8'($urandom),
           1'($urandom));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
